ct_spsram_64x108_ctrl: RTL and testbench
========================================

CT_SPSRAM_64X108_CTRL -- requirements
Module: ct_spsram_64x108_ctrl

Interface
REQ-001 forever_cpuclk  input  1  single clock; all state updates on its rising edge.
REQ-002 cpurst_b  input  1  reset, asynchronous, active-low.
REQ-003 init_start  input  1  one-cycle pulse requesting a full zero-clear of the array.
REQ-004 init_busy  output  1  high while the clear sequence runs.
REQ-005 wr_req  input  1  write request.
REQ-006 wr_addr  input  6  write entry index.
REQ-007 wr_data  input  108  write data.
REQ-008 wr_mask  input  4  active-high enable per 27-bit segment; bit i covers data bits 27*i+26 down to 27*i.
REQ-009 wr_gnt  output  1  write accepted this cycle.
REQ-010 rd_req  input  1  read request.
REQ-011 rd_addr  input  6  read entry index.
REQ-012 rd_gnt  output  1  read accepted this cycle.
REQ-013 rd_vld  output  1  read data valid.
REQ-014 rd_data  output  108  read data, meaningful only while rd_vld=1.
REQ-015 sram_cen  output  1  SRAM chip enable, active-low.
REQ-016 sram_gwen  output  1  SRAM global write enable, active-low.
REQ-017 sram_wen  output  108  SRAM per-bit write enable, active-low.
REQ-018 sram_a  output  6  SRAM address.
REQ-019 sram_d  output  108  SRAM write data.
REQ-020 sram_q  input  108  SRAM read data; valid the cycle after an access with sram_cen=0 and sram_gwen=1.

Function
REQ-021 The FSM SHALL have two states: INIT and RUN.
REQ-022 Reset SHALL place the FSM in INIT with the 6-bit clear counter at 0.
REQ-023 In INIT, each cycle SHALL drive sram_cen=0, sram_gwen=0, sram_wen all 0, sram_a=counter and sram_d=0, then increment the counter.
REQ-024 The cycle with counter=63 SHALL be the last INIT cycle (exactly 64 cycles); the FSM SHALL then go to RUN and clear the counter to 0.
REQ-025 init_busy SHALL be 1 exactly while in INIT.
REQ-026 wr_gnt and rd_gnt SHALL be 0 throughout INIT.
REQ-027 init_start SHALL be ignored while in INIT.
REQ-028 init_start sampled high in RUN SHALL move the FSM to INIT in the next cycle; grants in the sampling cycle SHALL proceed normally.
REQ-029 In RUN, a single requester SHALL be granted combinationally in the same cycle.
REQ-030 In RUN, if wr_req and rd_req are both high, exactly one SHALL be granted, chosen by a 1-bit priority pointer (0 = read first, 1 = write first).
REQ-031 The pointer SHALL toggle after every conflict cycle and SHALL otherwise hold.
REQ-032 The priority pointer SHALL reset to 0.
REQ-033 A granted read SHALL drive sram_cen=0, sram_gwen=1, sram_a=rd_addr and sram_wen all 1.
REQ-034 A granted write SHALL drive sram_a=wr_addr, sram_d=wr_data, and each sram_wen segment i = replicated ~wr_mask[i].
REQ-035 For a granted write, sram_cen and sram_gwen SHALL be 0 if wr_mask is nonzero.
REQ-036 A granted write with wr_mask=0 SHALL still assert wr_gnt but SHALL keep sram_cen=1 and SHALL not change the array.
REQ-037 With no grant in RUN, the block SHALL drive sram_cen=1 and sram_gwen=1, with sram_wen all 1.
REQ-038 rd_vld SHALL be registered and SHALL equal rd_gnt delayed by one cycle, giving a fixed read latency of 1 cycle.
REQ-039 rd_data SHALL equal sram_q combinationally while rd_vld=1.
REQ-040 When a write and a read of the same address are granted in consecutive cycles, the read SHALL return the written data; no bypass logic is required.
REQ-041 A requester SHALL hold req, addr, data and mask stable until it sees its gnt; the block does not latch ungranted requests.

Reset
REQ-042 While cpurst_b=0, the block SHALL hold FSM=INIT, counter=0, pointer=0 and rd_vld=0.
REQ-043 While cpurst_b=0, init_busy SHALL be 1, wr_gnt and rd_gnt SHALL be 0, and sram_cen SHALL be 1.
REQ-044 On release, the first INIT access SHALL occur in the first clock edge cycle.
REQ-045 Reset asserted mid-INIT or mid-read SHALL abort immediately and restart the clear from address 0; any pending rd_vld SHALL be lost.

Verification
REQ-046 Release reset -> 64 consecutive writes of zero to addresses 0..63 -> init_busy falls after the 64th write -> reading all entries returns 0.
REQ-047 In RUN, write addr 5, data all-ones, mask 4'b1111; then read addr 5 -> rd_vld one cycle after rd_gnt with rd_data all-ones.
REQ-048 Write addr 9 with mask 4'b0010 and data all-ones -> read returns only bits 53:27 set.
REQ-049 Hold wr_req and rd_req high for 4 cycles -> grants run rd, wr, rd, wr and the pointer ends at 0.
REQ-050 Pulse init_start in RUN while rd_req is high -> read granted that cycle and rd_vld occurs next cycle; grants then stay 0 for 64 cycles.
REQ-051 Assert cpurst_b=0 at INIT counter=30 -> after release, the clear restarts from address 0 and takes 64 full cycles.

Source files
------------

// File: rtl/ct_spsram_64x108_ctrl.sv
// ============================================================================
// ct_spsram_64x108_ctrl
// ----------------------------------------------------------------------------
// Controller for a 64-entry x 108-bit single-port SRAM macro.
//
// After reset (or on an init_start pulse while running), the whole array is
// cleared to zero. The controller writes zeros to addresses 0..63, one per
// cycle. When that finishes, it arbitrates between one write requester and
// one read requester for the single SRAM port. Grants are combinational.
// When both requesters ask in the same cycle, a one-bit round-robin pointer
// picks the winner. Read data comes back one cycle after the read grant and
// is passed straight through from the macro.
//
// Handshake rule (both requesters): a request is a level on *_req with its
// address/data/mask. It is accepted in a cycle only when the matching *_gnt
// is high in that same cycle. An ungranted request is not stored, so the
// requester keeps req, addr, data and mask stable until it sees gnt.
// rd_vld rises exactly one cycle after rd_gnt. There is no back-pressure on
// the read return path.
//
// Ports
//   forever_cpuclk   in   1    clock, rising edge
//   cpurst_b         in   1    asynchronous active-low reset
//   init_start       in   1    request a full zero-clear (ignored while clearing)
//   init_busy        out  1    clear sequence in progress
//   wr_req/addr/data/mask  in  write request, 6-bit index, 108-bit data,
//                              4-bit mask (one bit per 27-bit segment)
//   wr_gnt           out  1    write accepted this cycle
//   rd_req/addr      in        read request, 6-bit index
//   rd_gnt           out  1    read accepted this cycle
//   rd_vld           out  1    read data valid (rd_gnt delayed one cycle)
//   rd_data          out  108  read data, meaningful only while rd_vld=1
//   sram_cen/gwen    out  1    macro chip / global write enable, active-low
//   sram_wen         out  108  macro per-bit write enable, active-low
//   sram_a           out  6    macro address
//   sram_d           out  108  macro write data
//   sram_q           in   108  macro read data (valid the cycle after a read)
//   dbg_state_o      out  1    FSM state (0 = INIT, 1 = RUN)
//   dbg_clr_cnt_o    out  6    clear counter
//   dbg_prio_ptr_o   out  1    arbitration pointer (0 = read first)
// ============================================================================
module ct_spsram_64x108_ctrl (
    input  logic         forever_cpuclk,
    input  logic         cpurst_b,
    input  logic         init_start,
    output logic         init_busy,
    input  logic         wr_req,
    input  logic [5:0]   wr_addr,
    input  logic [107:0] wr_data,
    input  logic [3:0]   wr_mask,
    output logic         wr_gnt,
    input  logic         rd_req,
    input  logic [5:0]   rd_addr,
    output logic         rd_gnt,
    output logic         rd_vld,
    output logic [107:0] rd_data,
    output logic         sram_cen,
    output logic         sram_gwen,
    output logic [107:0] sram_wen,
    output logic [5:0]   sram_a,
    output logic [107:0] sram_d,
    input  logic [107:0] sram_q,
    output logic         dbg_state_o,
    output logic [5:0]   dbg_clr_cnt_o,
    output logic         dbg_prio_ptr_o
);

    localparam int          DW       = 108;
    localparam int          AW       = 6;
    localparam int          SEG_W    = 27;
    localparam int          NSEG     = 4;
    localparam logic [AW-1:0] LAST_IDX = 6'd63;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e          state_q, state_d;
    logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic            prio_ptr_q, prio_ptr_d;
    logic            rd_vld_q, rd_vld_d;

    // Arbitration results for the current cycle
    logic            in_run;
    logic            conflict;
    logic            wr_gnt_c;
    logic            rd_gnt_c;

    // Expanded write-enable (active-low) for a granted write
    logic [DW-1:0]   wr_wen_c;

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q    <= ST_INIT;
            clr_cnt_q  <= '0;
            prio_ptr_q <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            prio_ptr_q <= prio_ptr_d;
            rd_vld_q   <= rd_vld_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                // init_start is deliberately not looked at here. A clear
                // that is already running just runs to completion.
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 6'd1;
                end
            end
            ST_RUN: begin
                if (init_start) begin
                    state_d   = ST_INIT;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------
    // Gating with cpurst_b keeps both grants low for the whole time reset is
    // held, not just once the asynchronous clear has propagated.
    assign in_run   = (state_q == ST_RUN) && cpurst_b;
    assign conflict = wr_req && rd_req;

    // If only one requester asks, it wins. If both ask, prio_ptr_q decides:
    // 0 means the read goes first, 1 means the write goes first.
    assign rd_gnt_c = in_run && rd_req && (!wr_req || !prio_ptr_q);
    assign wr_gnt_c = in_run && wr_req && (!rd_req ||  prio_ptr_q);

    // The pointer flips after every conflict cycle so neither side can
    // starve the other. It holds in every other cycle.
    always_comb begin
        prio_ptr_d = prio_ptr_q;
        if (in_run && conflict) begin
            prio_ptr_d = !prio_ptr_q;
        end
    end

    // Fixed one-cycle read latency: the macro returns data the cycle after
    // a read access.
    assign rd_vld_d = rd_gnt_c;

    // ------------------------------------------------------------------------
    // SRAM port drive
    // ------------------------------------------------------------------------
    always_comb begin
        wr_wen_c = '1;
        for (int s = 0; s < NSEG; s++) begin
            wr_wen_c[s*SEG_W +: SEG_W] = {SEG_W{~wr_mask[s]}};
        end
    end

    always_comb begin
        // Idle by default: macro deselected, nothing written.
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_a    = '0;
        sram_d    = '0;

        if (state_q == ST_INIT) begin
            // Clear sweep: write zeros to every bit at clr_cnt_q.
            sram_cen  = 1'b0;
            sram_gwen = 1'b0;
            sram_wen  = '0;
            sram_a    = clr_cnt_q;
            sram_d    = '0;
        end else if (wr_gnt_c) begin
            sram_a   = wr_addr;
            sram_d   = wr_data;
            sram_wen = wr_wen_c;
            // An all-zero mask is still granted, so the requester can retire
            // it. The macro is left deselected, so the array is not touched.
            if (wr_mask != '0) begin
                sram_cen  = 1'b0;
                sram_gwen = 1'b0;
            end
        end else if (rd_gnt_c) begin
            sram_cen  = 1'b0;
            sram_gwen = 1'b1;
            sram_a    = rd_addr;
        end

        // Reset overrides everything. The state register already reads INIT
        // during reset, so without this override the macro would be enabled.
        if (!cpurst_b) begin
            sram_cen = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign init_busy      = (state_q == ST_INIT);
    assign wr_gnt         = wr_gnt_c;
    assign rd_gnt         = rd_gnt_c;
    assign rd_vld         = rd_vld_q;
    // Pass-through from the macro. Forced to zero outside rd_vld so stale
    // macro output is never visible.
    assign rd_data        = rd_vld_q ? sram_q : '0;

    assign dbg_state_o    = state_q;
    assign dbg_clr_cnt_o  = clr_cnt_q;
    assign dbg_prio_ptr_o = prio_ptr_q;

endmodule

// File: tb/tb_ct_spsram_64x108_ctrl.sv
module tb_ct_spsram_64x108_ctrl;

  localparam int DW    = 108;
  localparam int DEPTH = 64;

  // --------------------------------------------------------------------------
  // DUT signals
  // --------------------------------------------------------------------------
  logic          forever_cpuclk = 1'b0;
  logic          cpurst_b = 1'b0;
  logic          init_start = 1'b0;
  logic          init_busy;
  logic          wr_req = 1'b0;
  logic [5:0]    wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [3:0]    wr_mask = '0;
  logic          wr_gnt;
  logic          rd_req = 1'b0;
  logic [5:0]    rd_addr = '0;
  logic          rd_gnt;
  logic          rd_vld;
  logic [DW-1:0] rd_data;
  logic          sram_cen;
  logic          sram_gwen;
  logic [DW-1:0] sram_wen;
  logic [5:0]    sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q = '0;
  logic          dbg_state_o;
  logic [5:0]    dbg_clr_cnt_o;
  logic          dbg_prio_ptr_o;

  ct_spsram_64x108_ctrl dut (
    .forever_cpuclk (forever_cpuclk),
    .cpurst_b       (cpurst_b),
    .init_start     (init_start),
    .init_busy      (init_busy),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .wr_gnt         (wr_gnt),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_gnt         (rd_gnt),
    .rd_vld         (rd_vld),
    .rd_data        (rd_data),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q),
    .dbg_state_o    (dbg_state_o),
    .dbg_clr_cnt_o  (dbg_clr_cnt_o),
    .dbg_prio_ptr_o (dbg_prio_ptr_o)
  );

  // --------------------------------------------------------------------------
  // Clock
  // --------------------------------------------------------------------------
  initial begin
    forever #5 forever_cpuclk = ~forever_cpuclk;
  end

  // --------------------------------------------------------------------------
  // SRAM macro model (starts with random contents so the clear is visible)
  // --------------------------------------------------------------------------
  logic [DW-1:0] sram_mem [DEPTH];
  logic          mem_seeded = 1'b0;

  always @(posedge forever_cpuclk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < DEPTH; i++) begin
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        sram_mem[i] <= r[DW-1:0];
      end
      mem_seeded <= 1'b1;
    end else if (!sram_cen) begin
      if (!sram_gwen) sram_mem[sram_a] <= (sram_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= sram_mem[sram_a];
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard / reference model
  // --------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  logic          m_init;
  int            m_cnt;
  logic          m_ptr;
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] exp_q [$];

  // actual values sampled in the most recent cycle
  logic          act_wg, act_rg, act_cen, act_gwen, act_vld, act_busy, act_ptr;
  logic [5:0]    act_a, act_cnt;
  logic [DW-1:0] act_rdata;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs at negedge, check against the model,
  // then advance the model at the rising edge.
  task automatic cycle(input logic rst, input logic is, input logic wr, input logic [5:0] wa,
                       input logic [DW-1:0] wd, input logic [3:0] wm, input logic rd, input logic [5:0] ra);
    logic          e_wg, e_rg, e_cen, e_gwen, e_busy, chk_a, chk_d, chk_wen, chk_gwen;
    logic [DW-1:0] e_wen, e_d;
    logic [5:0]    e_a;
    @(negedge forever_cpuclk);
    cpurst_b = rst; init_start = is;
    wr_req = wr; wr_addr = wa; wr_data = wd; wr_mask = wm;
    rd_req = rd; rd_addr = ra;
    if (!rst) begin
      m_init = 1'b1; m_cnt = 0; m_ptr = 1'b0;
      exp_q.delete();
    end
    #1;
    e_wg = 0; e_rg = 0; e_cen = 1; e_gwen = 1; e_wen = '1; e_d = '0; e_a = '0;
    chk_a = 0; chk_d = 0; chk_wen = 0; chk_gwen = 0; e_busy = 1;
    if (rst && m_init) begin
      e_cen = 0; e_gwen = 0; e_wen = '0; e_a = 6'(m_cnt); e_d = '0;
      chk_a = 1; chk_d = 1; chk_wen = 1; chk_gwen = 1;
    end else if (rst) begin
      e_busy = 0;
      if (wr && rd) begin
        if (m_ptr) e_wg = 1; else e_rg = 1;
      end else begin
        e_wg = wr; e_rg = rd;
      end
      chk_wen = 1; chk_gwen = 1;
      if (e_rg) begin
        e_cen = 0; e_gwen = 1; e_a = ra; chk_a = 1;
      end
      if (e_wg) begin
        e_a = wa; e_d = wd; chk_a = 1; chk_d = 1;
        for (int s = 0; s < 4; s++) e_wen[27*s +: 27] = {27{~wm[s]}};
        if (wm != 4'd0) begin e_cen = 0; e_gwen = 0; end
        else chk_gwen = 0;
      end
    end

    act_wg = wr_gnt; act_rg = rd_gnt; act_cen = sram_cen; act_gwen = sram_gwen;
    act_vld = rd_vld; act_busy = init_busy; act_a = sram_a; act_rdata = rd_data;
    act_ptr = dbg_prio_ptr_o; act_cnt = dbg_clr_cnt_o;

    check("init_busy", 128'(init_busy), 128'(e_busy));
    check("wr_gnt", 128'(wr_gnt), 128'(e_wg));
    check("rd_gnt", 128'(rd_gnt), 128'(e_rg));
    check("sram_cen", 128'(sram_cen), 128'(e_cen));
    if (chk_gwen) check("sram_gwen", 128'(sram_gwen), 128'(e_gwen));
    if (chk_wen)  check("sram_wen", 128'(sram_wen), 128'(e_wen));
    if (chk_a)    check("sram_a", 128'(sram_a), 128'(e_a));
    if (chk_d)    check("sram_d", 128'(sram_d), 128'(e_d));
    check("rd_vld", 128'(rd_vld), 128'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("rd_data", 128'(rd_data), 128'(exp_q[0]));
    check("prio_ptr", 128'(dbg_prio_ptr_o), 128'(m_ptr));
    check("clr_cnt", 128'(dbg_clr_cnt_o), 128'(m_cnt));

    if (rst) begin
      @(posedge forever_cpuclk);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (e_rg) exp_q.push_back(m_mem[ra]);
      if (m_init) begin
        m_mem[m_cnt] = '0;
        if (m_cnt == DEPTH - 1) begin m_init = 1'b0; m_cnt = 0; end
        else m_cnt++;
      end else begin
        if (e_wg) begin
          for (int s = 0; s < 4; s++)
            if (wm[s]) m_mem[wa][27*s +: 27] = wd[27*s +: 27];
        end
        if (wr && rd) m_ptr = ~m_ptr;
        if (is) begin m_init = 1'b1; m_cnt = 0; end
      end
    end
  endtask

  task automatic idle(input logic rst);
    cycle(rst, 1'b0, 1'b0, 6'd0, '0, 4'd0, 1'b0, 6'd0);
  endtask

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic          wr;
    logic [5:0]    wa;
    logic [DW-1:0] wd;
    logic [3:0]    wm;
    logic          rd;
    logic [5:0]    ra;
    logic          e_wg, e_rg, e_cen, e_gwen, e_vld;
    logic [DW-1:0] e_data;
  } vec_t;

  function automatic vec_t mk(input logic wr, input logic [5:0] wa, input logic [DW-1:0] wd,
                              input logic [3:0] wm, input logic rd, input logic [5:0] ra,
                              input logic e_wg, input logic e_rg, input logic e_cen,
                              input logic e_gwen, input logic e_vld, input logic [DW-1:0] e_data);
    vec_t v;
    v.wr = wr; v.wa = wa; v.wd = wd; v.wm = wm; v.rd = rd; v.ra = ra;
    v.e_wg = e_wg; v.e_rg = e_rg; v.e_cen = e_cen; v.e_gwen = e_gwen;
    v.e_vld = e_vld; v.e_data = e_data;
    return v;
  endfunction

  vec_t tbl [12];

  // --------------------------------------------------------------------------
  // Test sequence
  // --------------------------------------------------------------------------
  initial begin
    logic [DW-1:0] ones, seg1, pat, zero, rnd;
    logic [127:0]  r;
    int            busy_cnt, gnt_cnt;
    logic          exp_wg [4];
    logic          exp_rg [4];

    ones = '1; zero = '0; seg1 = '0; seg1[53:27] = '1;
    pat  = 108'h123456789ABCDEF0123456789AB;

    //              wr wa     wd    wm     rd ra     wg rg cen gw vld data
    tbl[0]  = mk(0, 6'd0,  zero, 4'h0, 0, 6'd0,  0, 0, 1, 1, 0, zero);
    tbl[1]  = mk(1, 6'd5,  ones, 4'hF, 0, 6'd0,  1, 0, 0, 0, 0, zero);
    tbl[2]  = mk(0, 6'd0,  zero, 4'h0, 1, 6'd5,  0, 1, 0, 1, 0, zero);
    tbl[3]  = mk(1, 6'd7,  ones, 4'h0, 0, 6'd0,  1, 0, 1, 1, 1, ones);
    tbl[4]  = mk(1, 6'd9,  ones, 4'h2, 0, 6'd0,  1, 0, 0, 0, 0, zero);
    tbl[5]  = mk(0, 6'd0,  zero, 4'h0, 1, 6'd9,  0, 1, 0, 1, 0, zero);
    tbl[6]  = mk(1, 6'd20, pat,  4'hF, 1, 6'd5,  0, 1, 0, 1, 1, seg1);
    tbl[7]  = mk(1, 6'd20, pat,  4'hF, 1, 6'd5,  1, 0, 0, 0, 1, ones);
    tbl[8]  = mk(0, 6'd0,  zero, 4'h0, 1, 6'd5,  0, 1, 0, 1, 0, zero);
    tbl[9]  = mk(0, 6'd0,  zero, 4'h0, 1, 6'd7,  0, 1, 0, 1, 1, ones);
    tbl[10] = mk(0, 6'd0,  zero, 4'h0, 1, 6'd20, 0, 1, 0, 1, 1, zero);
    tbl[11] = mk(0, 6'd0,  zero, 4'h0, 0, 6'd0,  0, 0, 1, 1, 1, pat);

    m_init = 1'b1; m_cnt = 0; m_ptr = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;

    // Reset, then the power-on clear with requests and init_start toggling
    // (all must be ignored), then read back every entry.
    repeat (3) idle(1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'b1, 6'($urandom_range(0, 63)), r[DW-1:0],
            4'hF, 1'b1, 6'($urandom_range(0, 63)));
      if (i == 0) check("first_init_addr", 128'(act_a), 128'(0));
      busy_cnt += int'(act_busy);
    end
    check("init_busy_cycles", 128'(busy_cnt), 128'(64));
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 1'b0, 6'd0, '0, 4'd0, 1'b1, 6'(i));
    idle(1'b1);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 1'b0, tbl[i].wr, tbl[i].wa, tbl[i].wd, tbl[i].wm, tbl[i].rd, tbl[i].ra);
      check($sformatf("tbl%0d_wr_gnt", i), 128'(act_wg), 128'(tbl[i].e_wg));
      check($sformatf("tbl%0d_rd_gnt", i), 128'(act_rg), 128'(tbl[i].e_rg));
      check($sformatf("tbl%0d_cen", i), 128'(act_cen), 128'(tbl[i].e_cen));
      if (!(tbl[i].e_wg && tbl[i].wm == 4'd0))
        check($sformatf("tbl%0d_gwen", i), 128'(act_gwen), 128'(tbl[i].e_gwen));
      check($sformatf("tbl%0d_rd_vld", i), 128'(act_vld), 128'(tbl[i].e_vld));
      if (tbl[i].e_vld) check($sformatf("tbl%0d_rd_data", i), 128'(act_rdata), 128'(tbl[i].e_data));
    end

    // Four back-to-back conflict cycles: read, write, read, write
    exp_rg[0] = 1; exp_rg[1] = 0; exp_rg[2] = 1; exp_rg[3] = 0;
    exp_wg[0] = 0; exp_wg[1] = 1; exp_wg[2] = 0; exp_wg[3] = 1;
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, 1'b0, 1'b1, 6'd30, r[DW-1:0], 4'hF, 1'b1, 6'd30);
      check($sformatf("conflict%0d_rd", i), 128'(act_rg), 128'(exp_rg[i]));
      check($sformatf("conflict%0d_wr", i), 128'(act_wg), 128'(exp_wg[i]));
    end
    idle(1'b1);
    check("ptr_after_conflicts", 128'(act_ptr), 128'(0));

    // init_start while a read is requested
    cycle(1'b1, 1'b1, 1'b0, 6'd0, '0, 4'd0, 1'b1, 6'd30);
    check("init_start_rd_gnt", 128'(act_rg), 128'(1));
    busy_cnt = 0; gnt_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 6'd1, ones, 4'hF, 1'b1, 6'd1);
      if (i == 0) check("init_start_rd_vld", 128'(act_vld), 128'(1));
      busy_cnt += int'(act_busy);
      gnt_cnt  += int'(act_wg) + int'(act_rg);
    end
    check("reinit_busy_cycles", 128'(busy_cnt), 128'(64));
    check("reinit_grants", 128'(gnt_cnt), 128'(0));
    idle(1'b1);
    check("reinit_done", 128'(act_busy), 128'(0));

    // Reset in the middle of the clear, at counter 30
    repeat (2) idle(1'b0);
    repeat (30) idle(1'b1);
    idle(1'b1);
    check("mid_init_cnt", 128'(act_cnt), 128'(30));
    repeat (2) idle(1'b0);
    busy_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      idle(1'b1);
      if (i == 0) check("restart_addr", 128'(act_a), 128'(0));
      busy_cnt += int'(act_busy);
    end
    check("restart_busy_cycles", 128'(busy_cnt), 128'(64));
    idle(1'b1);
    check("restart_done", 128'(act_busy), 128'(0));

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      rnd = r[DW-1:0];
      cycle(1'b1, 1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 7)), rnd, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
